sdio_func_xfer_arbiter: RTL

//  Shares the single SDIO CMD53 block-transfer engine between NUM_FUNCS

---
 rtl/sdio_func_xfer_arbiter.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/sdio_func_xfer_arbiter.sv
// Round-robin arbiter sharing one SDIO CMD53 block engine between function requesters.
// Optional abort support is compiled in with SDIO_XFER_ABORT_EN.
module sdio_func_xfer_arbiter #(
    parameter int unsigned NUM_FUNCS  = 4,
    parameter int unsigned BLK_CNT_W  = 9,
    parameter int unsigned BLOCK_SIZE = 512
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_FUNCS-1:0]           i_req,
    input  logic [NUM_FUNCS-1:0]           i_req_write,
    input  logic [NUM_FUNCS*17-1:0]        i_req_addr,
    input  logic [NUM_FUNCS*BLK_CNT_W-1:0] i_req_count,
    output logic [NUM_FUNCS-1:0]           o_grant,
    output logic [NUM_FUNCS-1:0]           o_done,
    output logic [NUM_FUNCS-1:0]           o_err,
    output logic                           o_busy,
    output logic                           o_eng_start,
    input  logic                           i_eng_ready,
    output logic                           o_eng_write,
    output logic [16:0]                    o_eng_addr,
    output logic [2:0]                     o_eng_func,
    input  logic                           i_eng_blk_done,
`ifdef SDIO_XFER_ABORT_EN
    input  logic [NUM_FUNCS-1:0]           i_abort,
`endif
    input  logic                           i_eng_blk_err
);

    localparam int unsigned IDX_W  = (NUM_FUNCS > 1) ? $clog2(NUM_FUNCS) : 1;
    localparam int unsigned ADDR_W = 17;
    localparam int unsigned REM_W  = BLK_CNT_W + 1;

    typedef enum logic [2:0] {S_IDLE, S_GRANT, S_ISSUE, S_WAIT_BLK, S_FINISH} state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     gidx_q, gidx_d;
    logic [IDX_W-1:0]     rr_q, rr_d;
    logic [REM_W-1:0]     rem_q, rem_d;
    logic [NUM_FUNCS-1:0] grant_d, done_d, err_d;
    logic                 start_d, write_d, busy_d;
    logic [ADDR_W-1:0]    addr_d;
    logic [2:0]           func_d;

    logic                 pick_found;
    logic [IDX_W-1:0]     pick_idx, cand;
    logic [NUM_FUNCS-1:0] pick_onehot;
    logic                 sel_write;
    logic [ADDR_W-1:0]    sel_addr;
    logic [BLK_CNT_W-1:0] sel_count;
    logic                 abort_c;

    // First requester at or after the round-robin pointer, wrapping
    always_comb begin
        pick_found  = 1'b0;
        pick_idx    = '0;
        cand        = '0;
        pick_onehot = '0;
        for (int unsigned k = 0; k < NUM_FUNCS; k++) begin
            cand = IDX_W'((32'(rr_q) + k) % NUM_FUNCS);
            if (!pick_found && i_req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
        for (int unsigned f = 0; f < NUM_FUNCS; f++) begin
            pick_onehot[f] = pick_found && (pick_idx == IDX_W'(f));
        end
    end

    // Request fields of the granted function
    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_count = '0;
        for (int unsigned f = 0; f < NUM_FUNCS; f++) begin
            if (gidx_q == IDX_W'(f)) begin
                sel_write = i_req_write[f];
                sel_addr  = i_req_addr[f*ADDR_W +: ADDR_W];
                sel_count = i_req_count[f*BLK_CNT_W +: BLK_CNT_W];
            end
        end
    end

`ifdef SDIO_XFER_ABORT_EN
    logic abort_pend_q;
    // o_grant is only non-zero while a transfer is owned, so it qualifies the abort
    always_ff @(posedge clk) begin
        if (rst || state_q == S_FINISH) begin
            abort_pend_q <= 1'b0;
        end else if (|(i_abort & o_grant)) begin
            abort_pend_q <= 1'b1;
        end
    end
    assign abort_c = abort_pend_q | (|(i_abort & o_grant));
`else
    assign abort_c = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        gidx_d  = gidx_q;
        rr_d    = rr_q;
        rem_d   = rem_q;
        grant_d = o_grant;
        done_d  = '0;
        err_d   = '0;
        start_d = o_eng_start;
        write_d = o_eng_write;
        addr_d  = o_eng_addr;
        func_d  = o_eng_func;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    gidx_d  = pick_idx;
                    grant_d = pick_onehot;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                write_d = sel_write;
                addr_d  = sel_addr;
                rem_d   = (sel_count == '0) ? (REM_W'(1) << BLK_CNT_W) : REM_W'(sel_count);
                func_d  = 3'(gidx_q) + 3'd1;
                start_d = !abort_c;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (o_eng_start && i_eng_ready) begin
                    start_d = 1'b0;
                    state_d = S_WAIT_BLK;
                end else if (abort_c) begin
                    start_d = 1'b0;
                    err_d   = o_grant;
                    grant_d = '0;
                    state_d = S_FINISH;
                end
            end
            S_WAIT_BLK: begin
                if (i_eng_blk_done) begin
                    rem_d = rem_q - REM_W'(1);
                    if (i_eng_blk_err || abort_c) begin
                        err_d   = o_grant;
                        grant_d = '0;
                        state_d = S_FINISH;
                    end else if (rem_q == REM_W'(1)) begin
                        done_d  = o_grant;
                        grant_d = '0;
                        state_d = S_FINISH;
                    end else begin
                        addr_d  = o_eng_addr + ADDR_W'(BLOCK_SIZE);
                        start_d = 1'b1;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_FINISH: begin
                rr_d    = (gidx_q == IDX_W'(NUM_FUNCS - 1)) ? '0 : gidx_q + IDX_W'(1);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            gidx_q      <= '0;
            rr_q        <= '0;
            rem_q       <= '0;
            o_grant     <= '0;
            o_done      <= '0;
            o_err       <= '0;
            o_busy      <= 1'b0;
            o_eng_start <= 1'b0;
            o_eng_write <= 1'b0;
            o_eng_addr  <= '0;
            o_eng_func  <= '0;
        end else begin
            state_q     <= state_d;
            gidx_q      <= gidx_d;
            rr_q        <= rr_d;
            rem_q       <= rem_d;
            o_grant     <= grant_d;
            o_done      <= done_d;
            o_err       <= err_d;
            o_busy      <= busy_d;
            o_eng_start <= start_d;
            o_eng_write <= write_d;
            o_eng_addr  <= addr_d;
            o_eng_func  <= func_d;
        end
    end

endmodule
